// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU owns the single-port memory except for one
// HOST_ACC cycle per host access, with a bounded wait before the host is forced a grant.
module dmem_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              asyn_n_rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOST_ACC = 2'd1,
        HOST_ACK = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

    always_ff @(posedge clk or negedge asyn_n_rst) begin
        if (!asyn_n_rst) begin
            state_q      <= IDLE;
            wait_cnt_q   <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        host_rdata_d = host_rdata_q;
        host_ack     = 1'b0;
        cpu_stall    = 1'b0;
        mem_we       = cpu_req & cpu_we;
        mem_addr     = cpu_addr;
        mem_wdata    = cpu_wdata;

        case (state_q)
            IDLE: begin
                if (!host_req) begin
                    wait_cnt_d = '0;
                end else if (!cpu_req || wait_cnt_q >= MAX_W) begin
                    state_d    = HOST_ACC;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            HOST_ACC: begin
                // host_req is gated in so a request dropped early can never write
                mem_we     = host_req & host_we;
                mem_addr   = host_addr;
                mem_wdata  = host_wdata;
                cpu_stall  = cpu_req;
                wait_cnt_d = '0;
                if (!host_we) host_rdata_d = mem_rdata;
                state_d    = HOST_ACK;
            end
            HOST_ACK: begin
                host_ack   = 1'b1;
                wait_cnt_d = '0;
                state_d    = IDLE;
            end
            default: begin
                wait_cnt_d = '0;
                state_d    = IDLE;
            end
        endcase
    end

    assign cpu_rdata  = mem_rdata;
    assign host_rdata = host_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and random checks of dmem_arbiter against a behavioural RAM and reference copy.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        asyn_n_rst;
    logic        cpu_req, cpu_we, host_req, host_we;
    logic [7:0]  cpu_addr, host_addr, mem_addr;
    logic [31:0] cpu_wdata, cpu_rdata, host_wdata, host_rdata, mem_wdata, mem_rdata;
    logic        cpu_stall, host_ack, mem_we;

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
    assign mem_rdata = ram[mem_addr];

    dmem_arbiter #(.DATA_W(32), .ADDR_W(8), .MAX_WAIT(4)) dut (
        .clk(clk), .asyn_n_rst(asyn_n_rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic cyc;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        asyn_n_rst = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h03; cpu_wdata = 32'hAA;
        host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 32'h0;
        #1;
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b exp 0", host_ack); end
        checks++; if (host_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", host_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", cpu_stall); end
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL rst_mem_we got %b exp 1", mem_we); end
        checks++; if (mem_addr !== 8'h03) begin errors++; $display("FAIL rst_mem_addr got %h exp 03", mem_addr); end
        cpu_req = 1'b0; cpu_we = 1'b0;
        repeat (2) @(negedge clk);
        asyn_n_rst = 1'b1;
    endtask

    // REQ-033: host store with idle CPU
    task automatic test_host_store;
        cyc;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h00; host_wdata = 32'd57;
        cpu_req = 1'b0; cpu_addr = 8'h09;
        @(negedge clk);
        checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h09) begin errors++; $display("FAIL hs_idle got we=%b addr=%h exp we=0 addr=09", mem_we, mem_addr); end
        cyc; @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h00 || mem_wdata !== 32'd57) begin errors++; $display("FAIL hs_acc got we=%b addr=%h data=%h exp 1/00/39", mem_we, mem_addr, mem_wdata); end
        checks++; if (host_ack !== 1'b0 || cpu_stall !== 1'b0) begin errors++; $display("FAIL hs_acc_flags got ack=%b stall=%b exp 0/0", host_ack, cpu_stall); end
        cyc; @(negedge clk);
        checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL hs_ack got %b exp 1", host_ack); end
        checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h09) begin errors++; $display("FAIL hs_ack_mem got we=%b addr=%h exp 0/09", mem_we, mem_addr); end
        checks++; if (ram[0] !== 32'd57) begin errors++; $display("FAIL hs_ram got %h exp 39", ram[0]); end
        cyc; host_req = 1'b0;
        @(negedge clk);
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL hs_ack_pulse got %b exp 0", host_ack); end
    endtask

    // REQ-034: 4 losses plus the grant-decision IDLE cycle, one stall, then ack
    task automatic test_starvation;
        int pre = 0;
        int stalls = 0;
        bit got_ack = 0;
        cyc;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
        for (int i = 0; i < 14 && !got_ack; i++) begin
            @(negedge clk);
            if (host_ack) begin
                got_ack = 1;
                checks++; if (host_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sv_rdata got %h exp deadbeef", host_rdata); end
                checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL sv_ack_stall got %b exp 0", cpu_stall); end
            end else if (cpu_stall) begin
                stalls++;
                checks++; if (mem_addr !== 8'h20) begin errors++; $display("FAIL sv_acc_addr got %h exp 20", mem_addr); end
            end else if (stalls == 0) begin
                pre++;
            end
            cyc;
        end
        host_req = 1'b0; cpu_req = 1'b0;
        checks++; if (!got_ack) begin errors++; $display("FAIL sv_timeout got no ack exp ack"); end
        checks++; if (pre != 5) begin errors++; $display("FAIL sv_pre_cycles got %0d exp 5", pre); end
        checks++; if (stalls != 1) begin errors++; $display("FAIL sv_stalls got %0d exp 1", stalls); end
    endtask

    // REQ-035 / REQ-028: CPU load in HOST_ACK sees the host store
    task automatic test_forward;
        cyc;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h05; host_wdata = 32'h0000_0C99;
        cpu_req = 1'b0;
        cyc; cyc;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
        @(negedge clk);
        checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL fw_ack got %b exp 1", host_ack); end
        checks++; if (cpu_rdata !== 32'h0000_0C99) begin errors++; $display("FAIL fw_rdata got %h exp 00000c99", cpu_rdata); end
        checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL fw_stall got %b exp 0", cpu_stall); end
        cyc; host_req = 1'b0; cpu_req = 1'b0;
    endtask

    // REQ-036: ack on cycles 3, 6, 9; host writes only in HOST_ACC
    task automatic test_back_to_back;
        cyc;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h07; host_wdata = 32'h77;
        cpu_req = 1'b0; cpu_addr = 8'h10;
        for (int c = 1; c <= 9; c++) begin
            if (c > 1) cyc;
            @(negedge clk);
            checks++; if (host_ack !== (c % 3 == 0)) begin errors++; $display("FAIL b2b_ack c%0d got %b exp %b", c, host_ack, (c % 3 == 0)); end
            checks++; if (mem_we !== (c % 3 == 2)) begin errors++; $display("FAIL b2b_we c%0d got %b exp %b", c, mem_we, (c % 3 == 2)); end
        end
        cyc; host_req = 1'b0;
    endtask

    // REQ-037 / REQ-031 / REQ-032: reset mid HOST_ACC aborts without write or ack
    task automatic test_reset_abort;
        ram[8'h30] = 32'h55;
        cyc;
        host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 32'h1234;
        cpu_req = 1'b0; cpu_addr = 8'h11;
        cyc; #1;
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h30) begin errors++; $display("FAIL ab_acc got we=%b addr=%h exp 1/30", mem_we, mem_addr); end
        asyn_n_rst = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h11) begin errors++; $display("FAIL ab_async got we=%b addr=%h exp 0/11", mem_we, mem_addr); end
        checks++; if (host_ack !== 1'b0 || host_rdata !== 32'h0) begin errors++; $display("FAIL ab_outs got ack=%b rd=%h exp 0/0", host_ack, host_rdata); end
        cyc;
        asyn_n_rst = 1'b1;
        @(negedge clk);
        checks++; if (ram[8'h30] !== 32'h55) begin errors++; $display("FAIL ab_nowrite got %h exp 55", ram[8'h30]); end
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL ab_noack got %b exp 0", host_ack); end
        cyc; @(negedge clk);
        checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h30) begin errors++; $display("FAIL ab_regrant got we=%b addr=%h exp 1/30", mem_we, mem_addr); end
        cyc; @(negedge clk);
        checks++; if (host_ack !== 1'b1) begin errors++; $display("FAIL ab_reack got %b exp 1", host_ack); end
        cyc; host_req = 1'b0;
    endtask

    // REQ-038: random traffic on a small address window against ref_mem
    task automatic test_random;
        int  stall_cnt = 0;
        bit  ack_prev = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = ram[i];
        for (int n = 0; n < 400; n++) begin
            cyc;
            if (ack_prev) host_req = 1'b0;
            else if (!host_req && $urandom_range(3) == 0) begin
                host_req = 1'b1; host_we = 1'($urandom_range(1));
                host_addr = 8'($urandom_range(7)); host_wdata = $urandom;
            end
            cpu_req = 1'($urandom_range(1)); cpu_we = 1'($urandom_range(1));
            cpu_addr = 8'($urandom_range(7)); cpu_wdata = $urandom;
            @(negedge clk);
            ack_prev = host_ack;
            if (host_ack) begin
                checks++; if (stall_cnt > 1) begin errors++; $display("FAIL rnd_stalls n%0d got %0d exp <=1", n, stall_cnt); end
                stall_cnt = 0;
                if (host_we) ref_mem[host_addr] = host_wdata;
                else begin
                    checks++; if (host_rdata !== ref_mem[host_addr]) begin errors++; $display("FAIL rnd_host_ld n%0d got %h exp %h", n, host_rdata, ref_mem[host_addr]); end
                end
            end
            if (cpu_stall) stall_cnt++;
            if (cpu_req && !cpu_stall) begin
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else begin
                    checks++; if (cpu_rdata !== ref_mem[cpu_addr]) begin errors++; $display("FAIL rnd_cpu_ld n%0d got %h exp %h", n, cpu_rdata, ref_mem[cpu_addr]); end
                end
            end
            if (!cpu_req && !host_req) begin
                checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL rnd_idle_we n%0d got %b exp 0", n, mem_we); end
            end
        end
        cyc; host_req = 1'b0; cpu_req = 1'b0;
        repeat (4) cyc;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'(i) * 32'h0101_0101;
        ram[8'h20] = 32'hDEADBEEF;
        test_reset;
        test_host_store;
        test_starvation;
        test_forward;
        test_back_to_back;
        test_reset_abort;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: DATA_W, default 32, data word width of the CPU port, the host port and the memory port.
REQ-002 Parameter: ADDR_W, default 8, word-address width of the data memory index.
REQ-003 Parameter: MAX_WAIT, default 4, number of consecutive cycles the host may lose arbitration before it is forced a grant (range 1..15).
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 asyn_n_rst  in  1  asynchronous reset, active-low.
REQ-006 cpu_req  in  1  CPU load/store access request this cycle.
REQ-007 cpu_we  in  1  CPU access is a store (1) or a load (0).
REQ-008 cpu_addr  in  ADDR_W  CPU word address.
REQ-009 cpu_wdata  in  DATA_W  CPU store data.
REQ-010 cpu_rdata  out  DATA_W  CPU load data, combinational from mem_rdata.
REQ-011 cpu_stall  out  1  CPU access is not performed this cycle; the CPU holds PC and pipeline state.
REQ-012 host_req  in  1  host (loader/debug) access request; held with stable fields until host_ack.
REQ-013 host_we, host_addr, host_wdata  in  1/ADDR_W/DATA_W  host access type, address and store data.
REQ-014 host_rdata  out  DATA_W  registered host load data, valid while host_ack=1.
REQ-015 host_ack  out  1  one-cycle pulse that completes a host access.
REQ-016 mem_we, mem_addr, mem_wdata  out  1/ADDR_W/DATA_W  single-port data memory controls.
REQ-017 mem_rdata  in  DATA_W  asynchronous read data from memory at mem_addr.

Function
REQ-018 The block has three FSM states: IDLE, HOST_ACC and HOST_ACK.
REQ-019 The memory performs at most one access per cycle; the owner is the CPU unless the FSM is in HOST_ACC.
REQ-020 IDLE: when host_req=1 and (cpu_req=0 or wait_cnt=MAX_WAIT), the FSM goes to HOST_ACC on the next edge; otherwise it stays in IDLE.
REQ-021 IDLE: when host_req=1 and cpu_req=1 and wait_cnt<MAX_WAIT, wait_cnt increments; wait_cnt clears when host_req=0 or on entry to HOST_ACC.
REQ-022 HOST_ACC: mem_* carry the host fields; mem_we=host_we; cpu_stall=cpu_req; on the edge, host_rdata latches mem_rdata (loads only, held otherwise) and the FSM goes to HOST_ACK.
REQ-023 HOST_ACK: host_ack=1; the CPU owns memory; host_req is ignored this cycle; the FSM goes to IDLE on the next edge.
REQ-024 In IDLE and HOST_ACK: mem_addr/mem_wdata=cpu fields, mem_we=cpu_req&cpu_we, cpu_stall=0.
REQ-025 mem_we is never 1 when the current owner's request is 0.
REQ-026 A host access costs exactly one CPU stall cycle, and only if cpu_req=1 in HOST_ACC; host latency from grant decision to ack is 2 edges.
REQ-027 Back-to-back host requests yield at most one host access per 3 cycles; the CPU always gets HOST_ACK and at least one IDLE cycle between host accesses.
REQ-028 When the host and CPU address the same word in consecutive cycles, the order is host store, then CPU load, which returns the host data.
REQ-029 Unknown FSM encodings recover to IDLE on the next edge.

Reset
REQ-030 asyn_n_rst=0 forces immediately: FSM=IDLE, wait_cnt=0, host_ack=0, host_rdata=0, cpu_stall=0; mem_* follow the CPU fields with mem_we=cpu_req&cpu_we.
REQ-031 Reset asserted in HOST_ACC aborts the host access with no ack; the host shall re-issue the request after release.
REQ-032 The first edge after release evaluates IDLE arbitration normally.

Verification
REQ-033 Host-only store addr 0 data 57, cpu_req=0 -> HOST_ACC next cycle with mem_we=1, mem_addr=0; host_ack the cycle after; ram[0]=57.
REQ-034 cpu_req=1 continuously, host load held, MAX_WAIT=4 -> 4 IDLE losses, then HOST_ACC with cpu_stall=1 for exactly 1 cycle, then host_ack with host_rdata=ram[addr].
REQ-035 Host store 0x0000_0C99 to addr 5, then CPU load addr 5 in HOST_ACK -> cpu_rdata=0x0000_0C99 and cpu_stall=0.
REQ-036 host_req held high for 9 cycles with cpu_req=0 -> host_ack at cycles 3, 6 and 9 only; no mem access by the host in HOST_ACK.
REQ-037 asyn_n_rst pulsed low mid-cycle in HOST_ACC -> outputs reset without waiting for an edge; no host_ack; memory is not written on the next edge.
REQ-038 Random cpu/host traffic vs. a reference memory model -> every ack'd host load and every unstalled CPU load matches the model; cpu_stall never exceeds 1 cycle per host access.
